// File: rtl/swo_manch_rx_pkg.sv
// Shared definitions for the SWO Manchester receiver: FSM states and the
// threshold scaling used to classify edges against the measured half-bit.
package swo_manch_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // Mid-bit threshold is 3*halfbit/2; idle timeout is 8*halfbit.
  localparam int MID_MUL   = 3;
  localparam int MID_SHIFT = 1;
  localparam int END_SHIFT = 3;

endpackage

// File: rtl/swo_manch_rx_byte_fifo.sv
// Small first-word-fall-through byte FIFO; head is visible whenever rd_valid.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module swo_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       wr_drop,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          pop, wr_acc;

  assign rd_valid = (count_q != '0);
  assign pop      = rd_ready && rd_valid;
  assign wr_acc   = wr_en && ((count_q != DEPTH_C) || pop);
  assign wr_drop  = wr_en && !wr_acc;
  assign rd_data  = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/swo_manch_rx.sv
// Manchester SWO receiver: synchronise + deglitch the pin, calibrate the half-bit
// from each start bit, decode LSB-first bytes into a FIFO and flag packet errors.
module swo_manch_rx
  import swo_manch_rx_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int FILT_LEN    = 2,
  parameter int MIN_HALFBIT = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             swo_in,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             pkt_end,
  output logic             err_frame,
  output logic             err_overflow,
  output logic             err_sync,
  output logic [CNT_W-1:0] halfbit_len
);
  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) + 1 : 1;
  localparam int TW = CNT_W + 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TW-1:0]    MIN_HB  = TW'(MIN_HALFBIT);

  logic             sync1_q, sync2_q, line_q, line_d, line_prev_q;
  logic [FW-1:0]    run_q, run_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, hb_q, hb_d;
  logic [2:0]       bitidx_q, bitidx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             push_q, push_d, pkt_end_q, pkt_end_d, err_frame_q, err_frame_d;
  logic             err_sync_q, err_sync_d, err_ovf_q, fifo_drop;
  logic             line_edge, cnt_sat;
  logic [TW-1:0]    hb_x, cnt_x, thr_mid, thr_end;

  // A level change is accepted only after FILT_LEN consecutive differing samples.
  always_comb begin
    line_d = line_q;
    run_d  = '0;
    if (sync2_q != line_q) begin
      if (int'(run_q) + 1 >= FILT_LEN) line_d = sync2_q;
      else run_d = run_q + 1'b1;
    end
  end

  assign line_edge = line_q ^ line_prev_q;
  assign cnt_sat   = (cnt_q == CNT_MAX);
  assign cnt_inc   = cnt_sat ? cnt_q : cnt_q + 1'b1;
  assign hb_x      = TW'(hb_q);
  assign cnt_x     = TW'(cnt_q);
  assign thr_mid   = (hb_x * TW'(MID_MUL)) >> MID_SHIFT;
  assign thr_end   = hb_x << END_SHIFT;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_inc;
    hb_d        = hb_q;
    bitidx_d    = bitidx_q;
    shreg_d     = shreg_q;
    push_d      = 1'b0;
    pkt_end_d   = 1'b0;
    err_frame_d = 1'b0;
    err_sync_d  = 1'b0;
    if (!en) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      bitidx_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d    = '0;
          bitidx_d = '0;
          if (line_edge && line_q) begin
            state_d = ST_SYNC;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_SYNC: begin
          if (line_edge) begin
            if (cnt_x < MIN_HB) begin
              err_sync_d = 1'b1;
              state_d    = ST_IDLE;
              cnt_d      = '0;
            end else begin
              hb_d     = cnt_q;
              bitidx_d = '0;
              cnt_d    = CNT_W'(1);
              state_d  = ST_DATA;
            end
          end else if (cnt_sat) begin
            err_sync_d = 1'b1;
            state_d    = ST_IDLE;
            cnt_d      = '0;
          end
        end
        ST_DATA: begin
          // Boundary edges (close to the last mid-bit) are ignored and do not restart cnt.
          if (line_edge) begin
            if (cnt_x > thr_mid) begin
              shreg_d  = {line_prev_q, shreg_q[7:1]};
              bitidx_d = bitidx_q + 3'd1;
              cnt_d    = CNT_W'(1);
              push_d   = (bitidx_q == 3'd7);
            end
          end else if (cnt_x > thr_end || cnt_sat) begin
            // Saturation also ends the packet so a huge halfbit cannot stall here.
            pkt_end_d   = 1'b1;
            err_frame_d = (bitidx_q != 3'd0);
            state_d     = ST_IDLE;
            cnt_d       = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      line_q      <= 1'b0;
      line_prev_q <= 1'b0;
      run_q       <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hb_q        <= '0;
      bitidx_q    <= '0;
      shreg_q     <= '0;
      push_q      <= 1'b0;
      pkt_end_q   <= 1'b0;
      err_frame_q <= 1'b0;
      err_sync_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      sync1_q     <= swo_in;
      sync2_q     <= sync1_q;
      line_q      <= line_d;
      line_prev_q <= line_q;
      run_q       <= run_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hb_q        <= hb_d;
      bitidx_q    <= bitidx_d;
      shreg_q     <= shreg_d;
      push_q      <= push_d;
      pkt_end_q   <= pkt_end_d;
      err_frame_q <= err_frame_d;
      err_sync_q  <= err_sync_d;
      err_ovf_q   <= fifo_drop;
    end
  end

  swo_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (push_q),
    .wr_data  (shreg_q),
    .wr_drop  (fifo_drop),
    .rd_data  (m_data),
    .rd_valid (m_valid),
    .rd_ready (m_ready)
  );

  assign pkt_end      = pkt_end_q;
  assign err_frame    = err_frame_q;
  assign err_sync     = err_sync_q;
  assign err_overflow = err_ovf_q;
  assign halfbit_len  = hb_q;

endmodule

// File: tb/tb_swo_manch_rx.sv
// Bench for swo_manch_rx: drives Manchester packets on the pin and checks decoded
// bytes and status pulses against a queue-based model of the expected traffic.
module tb_swo_manch_rx;
  localparam int CNT_W = 16, FILT_LEN = 2, MIN_HB = 4, DEPTH = 4;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, swo_in = 1'b0, m_ready = 1'b0;
  logic [7:0] m_data;
  logic m_valid, pkt_end, err_frame, err_overflow, err_sync;
  logic [CNT_W-1:0] halfbit_len;

  always #5 clk = ~clk;

  swo_manch_rx #(.CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .MIN_HALFBIT(MIN_HB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .swo_in(swo_in),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .pkt_end(pkt_end), .err_frame(err_frame), .err_overflow(err_overflow),
    .err_sync(err_sync), .halfbit_len(halfbit_len)
  );

  int checks = 0, errors = 0;
  byte unsigned exp_q[$], recv_q[$], pk[$];
  int ready_mode = 0;
  int n_end = 0, n_frame = 0, n_ovf = 0, n_sync = 0;
  int e_end = 0, e_frame = 0, e_ovf = 0, e_sync = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always begin
    @(negedge clk);
    case (ready_mode)
      0: m_ready = 1'b1;
      1: m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  // Compare process: outputs are sampled mid-low-phase, after inputs have settled.
  logic prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && m_valid) check("m_data_hold", m_data, prev_data);
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %02h, required no byte", m_data);
        end else begin
          automatic byte unsigned e = exp_q.pop_front();
          if (m_data != e) begin
            errors++;
            $display("FAIL byte: got %02h, required %02h", m_data, e);
          end
          recv_q.push_back(m_data);
          $display("rx byte %02h (halfbit_len %0d)", m_data, halfbit_len);
        end
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      if (pkt_end) n_end++;
      if (err_frame) n_frame++;
      if (err_overflow) n_ovf++;
      if (err_sync) n_sync++;
      if (err_frame) check("frame_with_pkt_end", pkt_end, 1);
      if (pkt_end || err_overflow || err_sync)
        check("pulse_exclusive", int'(pkt_end) + int'(err_overflow) + int'(err_sync), 1);
    end
  end

  task automatic half(input logic lvl, input int hb);
    swo_in = lvl;
    repeat (hb) @(negedge clk);
  endtask

  task automatic model_push(input byte unsigned b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else e_ovf++;
  endtask

  // Each bit: first half carries the bit, second half its complement; LSB first.
  task automatic send_bits(input byte unsigned b, input int n, input int hb);
    for (int i = 0; i < n; i++) begin
      half(b[i], hb);
      if (i == 7) model_push(b);
      half(~b[i], hb);
    end
  endtask

  task automatic send_packet(input int pbits, input byte unsigned pval, input int hb);
    half(1'b1, hb);
    half(1'b0, hb);
    foreach (pk[k]) send_bits(pk[k], 8, hb);
    if (pbits > 0) send_bits(pval, pbits, hb);
    swo_in = 1'b0;
    repeat (8 * hb + 30) @(negedge clk);
    e_end++;
    if (pbits > 0) e_frame++;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || m_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    #3;
    check({name, "_left_in_model"}, exp_q.size(), 0);
    check({name, "_m_valid_after_drain"}, m_valid, 0);
  endtask

  task automatic check_counts(input string name);
    check({name, "_pkt_end_count"}, n_end, e_end);
    check({name, "_err_frame_count"}, n_frame, e_frame);
    check({name, "_err_overflow_count"}, n_ovf, e_ovf);
    check({name, "_err_sync_count"}, n_sync, e_sync);
  endtask

  initial begin
    #200_0000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hb, nb, pbits;
    #1;
    check("reset_m_valid", m_valid, 0);
    check("reset_halfbit_len", halfbit_len, 0);
    check("reset_pulses", {pkt_end, err_frame, err_overflow, err_sync}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    repeat (5) @(negedge clk);

    // 1: two bytes at halfbit 10
    ready_mode = 0;
    recv_q.delete();
    pk.delete(); pk.push_back(8'hA5); pk.push_back(8'h3C);
    send_packet(0, 8'h00, 10);
    drain("t1");
    check("t1_rx_count", recv_q.size(), 2);
    if (recv_q.size() == 2) begin
      check("t1_byte0", recv_q[0], 8'hA5);
      check("t1_byte1", recv_q[1], 8'h3C);
    end
    check("t1_halfbit_len", halfbit_len, 10);
    check("t1_one_pkt_end", n_end, 1);
    check_counts("t1");

    // 2: glitches on the idle line
    swo_in = 1'b1; @(negedge clk); swo_in = 1'b0;
    repeat (30) @(negedge clk);
    check_counts("t2_short_glitch");
    swo_in = 1'b1; repeat (3) @(negedge clk); swo_in = 1'b0;
    e_sync++;
    repeat (30) @(negedge clk);
    check_counts("t2_3clk_pulse");
    check("t2_halfbit_kept", halfbit_len, 10);

    // 3: overflow with consumer stalled
    ready_mode = 2;
    recv_q.delete();
    pk.delete();
    pk.push_back(8'h01); pk.push_back(8'h23); pk.push_back(8'h45);
    pk.push_back(8'h67); pk.push_back(8'h89); pk.push_back(8'hAB);
    send_packet(0, 8'h00, 10);
    check("t3_ovf_pulses", n_ovf, 2);
    check_counts("t3");
    ready_mode = 0;
    drain("t3");
    check("t3_rx_count", recv_q.size(), 4);
    if (recv_q.size() == 4) begin
      check("t3_byte0", recv_q[0], 8'h01);
      check("t3_byte3", recv_q[3], 8'h67);
    end

    // 4: full byte then 3 stray bits
    recv_q.delete();
    pk.delete(); pk.push_back(8'h55);
    send_packet(3, 8'h05, 10);
    drain("t4");
    check("t4_rx_count", recv_q.size(), 1);
    if (recv_q.size() == 1) check("t4_byte", recv_q[0], 8'h55);
    check_counts("t4");

    // 5: bit-rate change between packets
    pk.delete(); pk.push_back(8'hC3);
    send_packet(0, 8'h00, 10);
    check("t5_halfbit_10", halfbit_len, 10);
    pk.delete(); pk.push_back(8'h5A); pk.push_back(8'h0F);
    send_packet(0, 8'h00, 37);
    check("t5_halfbit_37", halfbit_len, 37);
    drain("t5");
    check_counts("t5");

    // 6a: reset mid-byte loses FIFO contents
    ready_mode = 2;
    pk.delete(); pk.push_back(8'h11);
    send_packet(0, 8'h00, 10);
    check("t6_fifo_loaded", m_valid, 1);
    half(1'b1, 10); half(1'b0, 10);
    send_bits(8'h0F, 4, 10);
    rst_n = 1'b0;
    #1;
    check("t6_rst_m_valid", m_valid, 0);
    check("t6_rst_halfbit_len", halfbit_len, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    swo_in = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    ready_mode = 0;
    recv_q.delete();
    pk.delete(); pk.push_back(8'h96);
    send_packet(0, 8'h00, 12);
    drain("t6_after_reset");
    check("t6_rst_rx", recv_q.size(), 1);
    check("t6_rst_halfbit", halfbit_len, 12);
    check_counts("t6_reset");

    // 6b: en low mid-byte keeps FIFO contents, no pulses
    ready_mode = 2;
    pk.delete(); pk.push_back(8'h22);
    send_packet(0, 8'h00, 10);
    half(1'b1, 10); half(1'b0, 10);
    send_bits(8'hF0, 4, 10);
    en = 1'b0;
    swo_in = 1'b0;
    repeat (120) @(negedge clk);
    #3;
    check("t6_en_fifo_kept", m_valid, 1);
    check("t6_en_head", m_data, 8'h22);
    check_counts("t6_en_low");
    en = 1'b1;
    ready_mode = 0;
    drain("t6_en");
    recv_q.delete();
    pk.delete(); pk.push_back(8'h7E);
    send_packet(0, 8'h00, 10);
    drain("t6_en_after");
    check("t6_en_rx", recv_q.size(), 1);
    check_counts("t6_en");

    // Random traffic with a random-ready consumer
    ready_mode = 1;
    for (int p = 0; p < 12; p++) begin
      hb = int'($urandom_range(6, 30));
      nb = int'($urandom_range(1, 3));
      pbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      pk.delete();
      for (int k = 0; k < nb; k++) pk.push_back(8'($urandom_range(0, 255)));
      send_packet(pbits, 8'($urandom_range(0, 255)), hb);
      $display("packet %0d: %0d bytes, %0d stray bits, halfbit %0d", p, nb, pbits, hb);
      check("rand_halfbit_len", halfbit_len, hb);
      check_counts("rand");
    end
    drain("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
